serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that uses a single `all_adder` full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It sits directly upstream of the full-adder cell: it latches operands, feeds the cell one bit pair per cycle, and registers the cell's carry between cycles. It also collects the cell's sum bits into a result register. This gives a small-area alternative to the combinational 16-bit ripple-carry chain, with a start/busy/done handshake toward the surrounding logic.

---
 rtl/serial_adder_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder that feeds one full-adder cell one bit pair per clock, LSB first.
// Start to done is WIDTH+1 cycles; start is ignored while busy. SERIAL_ADDER_SUB_EN adds a subtract input.

module all_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic ans,
   output logic carry_out
);
   assign ans       = a ^ b ^ cin;
   assign carry_out = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last_bit;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             c;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] part;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             fa_ans;
   logic             fa_co;
   logic             unused_part_lsb;

   all_adder u_fa (
      .a         (sa[0]),
      .b         (sb[0]),
      .cin       (c),
      .ans       (fa_ans),
      .carry_out (fa_co)
   );

`ifdef SERIAL_ADDER_SUB_EN
   // a - b computed as a + ~b + 1; carry_out=1 then means no borrow
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : carry_in;
`else
   assign b_load = b;
   assign c_load = carry_in;
`endif

   assign last_bit = (cnt == CW'(WIDTH - 1));

   // The partial register's LSB is always shifted out before the result is taken.
   assign unused_part_lsb = part[0];

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sa        <= '0;
         sb        <= '0;
         c         <= 1'b0;
         cnt       <= '0;
         part      <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            sa   <= a;
            sb   <= b_load;
            c    <= c_load;
            cnt  <= '0;
            part <= '0;
         end else if (state == RUN) begin
            sa   <= {1'b0, sa[WIDTH-1:1]};
            sb   <= {1'b0, sb[WIDTH-1:1]};
            c    <= fa_co;
            cnt  <= cnt + CW'(1);
            part <= {fa_ans, part[WIDTH-1:1]};
            // On the last bit, c is the carry into the MSB stage
            if (last_bit) begin
               sum       <= {fa_ans, part[WIDTH-1:1]};
               carry_out <= fa_co;
               overflow  <= c ^ fa_co;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected results are queued at start and checked on done.
module tb_serial_adder_ctrl;
   localparam int W = 16;
   localparam int LAT = W + 1;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         co;
      logic         ov;
      logic [31:0]  t0;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub = 1'b0;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   exp_t sb_q[$];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic do_sub);
      exp_t         e;
      logic [W-1:0] yy;
      logic [W:0]   full;
      yy      = do_sub ? ~y : y;
      full    = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (do_sub ? 1'b1 : ci)};
      e.sum   = full[W-1:0];
      e.co    = full[W];
      e.ov    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
      e.t0    = 32'(cyc);
      return e;
   endfunction

   // Drive start for one cycle from a negedge and queue the expected result.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic do_sub);
      a        = x;
      b        = y;
      carry_in = ci;
`ifdef SERIAL_ADDER_SUB_EN
      sub      = do_sub;
`endif
      start    = 1'b1;
      sb_q.push_back(model(x, y, ci, do_sub));
      @(negedge clk);
      start    = 1'b0;
      a        = $urandom;
      b        = $urandom;
      carry_in = 1'($urandom);
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!done && k < 3 * LAT) begin
         @(negedge clk);
         k++;
      end
      if (!done) check({tag, "_timeout"}, 64'd1, 64'd0);
   endtask

   always @(negedge clk) begin
      if (done) begin
         check("busy_done_excl", {63'd0, busy}, 64'd0);
         if (sb_q.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sum", 64'(sum), 64'(e.sum));
            check("carry_out", {63'd0, carry_out}, {63'd0, e.co});
            check("overflow", {63'd0, overflow}, {63'd0, e.ov});
            check("latency", 64'(cyc - int'(e.t0)), 64'(LAT));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d outputs still pending", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_co", {63'd0, carry_out}, 64'd0);
      check("rst_ov", {63'd0, overflow}, 64'd0);

      issue(16'h0001, 16'hFFFF, 1'b0, 1'b0);
      wait_done("op1");
      @(negedge clk);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait_done("op2");
      @(negedge clk);
      issue(16'h1234, 16'h4321, 1'b1, 1'b0);
      wait_done("op3");

      // Back-to-back from the DONE cycle, with a stray start mid-run
      issue(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("midrun_busy", {63'd0, busy}, 64'd1);
      wait_done("b2b1");
      issue(16'h8000, 16'h8000, 1'b1, 1'b0);
      wait_done("b2b2");
      @(negedge clk);

      // Reset in the middle of a run: no result, outputs back to zero
      a = 16'h1111; b = 16'h2222; carry_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_sum", 64'(sum), 64'd0);
      repeat (2 * LAT) @(negedge clk);
      check("abort_no_done", {63'd0, done}, 64'd0);
      issue(16'h00FF, 16'h0F0F, 1'b1, 1'b0);
      wait_done("post_rst");
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
         wait_done("rand");
         @(negedge clk);
      end

`ifdef SERIAL_ADDER_SUB_EN
      issue(16'h0005, 16'h0007, 1'b1, 1'b1);
      wait_done("sub1");
      @(negedge clk);
      issue(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done("sub2");
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         wait_done("rand_sub");
         @(negedge clk);
      end
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
